// File: rtl/window_load_sequencer_pkg.sv
// Shared window-size codes, sequencer state encoding and size helpers.
// The window-size decode logic uses the same constants.
package window_load_sequencer_pkg;

    localparam logic [1:0] WSZ_4       = 2'd0;
    localparam logic [1:0] WSZ_8       = 2'd1;
    localparam logic [1:0] WSZ_16      = 2'd2;
    localparam logic [1:0] WSZ_ILLEGAL = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ISSUE,
        ST_FINISH
    } state_t;

    function automatic logic [4:0] win_size(input logic [1:0] code);
        return 5'd4 << code;
    endfunction

    // Highest counter index for a legal code; fits the 4-bit counters.
    function automatic logic [3:0] win_max(input logic [1:0] code);
        logic [4:0] s;
        s = win_size(code) - 5'd1;
        return s[3:0];
    endfunction

endpackage

// File: rtl/window_load_sequencer_if.sv
// Word-load request channel from the sequencer to the data-memory read port.
interface window_load_sequencer_if #(
    parameter int ADDR_W = 32
);
    logic              ld_valid;
    logic              ld_ready;
    logic [ADDR_W-1:0] ld_addr;
    logic              ld_last;

    modport master (output ld_valid, ld_addr, ld_last, input  ld_ready);
    modport slave  (input  ld_valid, ld_addr, ld_last, output ld_ready);
endinterface

// File: rtl/window_load_sequencer_addr_gen.sv
// Row/column counters and the registered load address for one window walk.
// The address is kept as a register so it is stable across memory stalls.
module window_addr_gen
    import window_load_sequencer_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int FCOL_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              setup,
    input  logic              advance,
    input  logic [1:0]        wcol_code,
    input  logic [1:0]        wrow_code,
    input  logic [ADDR_W-1:0] frame_base,
    input  logic [FCOL_W-1:0] frame_cols,
    input  logic [FCOL_W-1:0] origin_row,
    input  logic [FCOL_W-1:0] origin_col,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    logic [ADDR_W-1:0] row_addr;
    logic [ADDR_W-1:0] row_step;
    logic [ADDR_W-1:0] origin_off;
    logic [ADDR_W-1:0] next_row;
    logic [3:0]        c, r, cmax, rmax;

    assign row_step   = ADDR_W'(frame_cols) << 2;
    assign origin_off = (ADDR_W'(origin_row) * ADDR_W'(frame_cols) + ADDR_W'(origin_col)) << 2;
    assign next_row   = row_addr + row_step;

    always_ff @(posedge clk) begin
        if (rst) begin
            row_addr <= '0;
            addr     <= '0;
            c        <= '0;
            r        <= '0;
            cmax     <= '0;
            rmax     <= '0;
        end else if (setup) begin
            row_addr <= frame_base + origin_off;
            addr     <= frame_base + origin_off;
            c        <= '0;
            r        <= '0;
            cmax     <= win_max(wcol_code);
            rmax     <= win_max(wrow_code);
        end else if (advance) begin
            if (c == cmax) begin
                c        <= '0;
                r        <= r + 4'd1;
                row_addr <= next_row;
                addr     <= next_row;
            end else begin
                c    <= c + 4'd1;
                addr <= addr + ADDR_W'(4);
            end
        end
    end

    assign last = (r == rmax) && (c == cmax);

endmodule

// File: rtl/window_load_sequencer.sv
// Walks one frame window row-major and issues one word-load request per element.
// FSM and handshake live here; counters and address math live in window_addr_gen.
module window_load_sequencer
    import window_load_sequencer_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int FCOL_W = 8
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     start,
    input  logic [1:0]               wcol_code,
    input  logic [1:0]               wrow_code,
    input  logic [ADDR_W-1:0]        frame_base,
    input  logic [FCOL_W-1:0]        frame_cols,
    input  logic [FCOL_W-1:0]        origin_row,
    input  logic [FCOL_W-1:0]        origin_col,
    window_load_sequencer_if.master  ld,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    state_t            state_q, state_d;
    logic              err_q, err_d;
    logic              setup, advance, last;
    logic [ADDR_W-1:0] addr;

    logic [1:0]        lat_wcol, lat_wrow;
    logic [ADDR_W-1:0] lat_base;
    logic [FCOL_W-1:0] lat_cols, lat_orow, lat_ocol;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q  <= ST_IDLE;
            err_q    <= 1'b0;
            lat_wcol <= '0;
            lat_wrow <= '0;
            lat_base <= '0;
            lat_cols <= '0;
            lat_orow <= '0;
            lat_ocol <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            if (state_q == ST_IDLE && start) begin
                lat_wcol <= wcol_code;
                lat_wrow <= wrow_code;
                lat_base <= frame_base;
                lat_cols <= frame_cols;
                lat_orow <= origin_row;
                lat_ocol <= origin_col;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        setup   = 1'b0;
        advance = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (wcol_code == WSZ_ILLEGAL || wrow_code == WSZ_ILLEGAL)
                        err_d = 1'b1;
                    else
                        state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                setup   = 1'b1;
                state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                // ld_valid is high throughout ISSUE, so ready alone completes the handshake
                if (ld.ld_ready) begin
                    advance = 1'b1;
                    if (last)
                        state_d = ST_FINISH;
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    window_addr_gen #(
        .ADDR_W (ADDR_W),
        .FCOL_W (FCOL_W)
    ) u_addr_gen (
        .clk        (Clk),
        .rst        (Rst),
        .setup      (setup),
        .advance    (advance),
        .wcol_code  (lat_wcol),
        .wrow_code  (lat_wrow),
        .frame_base (lat_base),
        .frame_cols (lat_cols),
        .origin_row (lat_orow),
        .origin_col (lat_ocol),
        .addr       (addr),
        .last       (last)
    );

    assign ld.ld_valid = (state_q == ST_ISSUE);
    assign ld.ld_addr  = addr;
    assign ld.ld_last  = (state_q == ST_ISSUE) && last;
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_FINISH);
    assign err         = err_q;

endmodule

// File: tb/tb_window_load_sequencer.sv
// Directed bench for window_load_sequencer: address walk, stalls, illegal codes,
// ignored starts and mid-window reset, checked against a small address model.
module tb_window_load_sequencer;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        start;
    logic [1:0]  wcol_code, wrow_code;
    logic [31:0] frame_base;
    logic [7:0]  frame_cols, origin_row, origin_col;
    logic        busy, done, err;
    int          n_tests = 0;
    int          n_fail  = 0;

    logic [31:0] first_a, last_a;
    int          hs;

    window_load_sequencer_if #(.ADDR_W(32)) ld ();

    window_load_sequencer #(.ADDR_W(32), .FCOL_W(8)) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .start      (start),
        .wcol_code  (wcol_code),
        .wrow_code  (wrow_code),
        .frame_base (frame_base),
        .frame_cols (frame_cols),
        .origin_row (origin_row),
        .origin_col (origin_col),
        .ld         (ld),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic start_window(input logic [1:0] wc, input logic [1:0] wr, input logic [31:0] base,
                                input logic [7:0] cols, input logic [7:0] orow, input logic [7:0] ocol);
        wcol_code  = wc;
        wrow_code  = wr;
        frame_base = base;
        frame_cols = cols;
        origin_row = orow;
        origin_col = ocol;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        chk("setup_valid", ld.ld_valid, 0);
        chk("setup_busy", busy, 1);
        tick();
    endtask

    // Walks the ISSUE phase; call right after start_window.
    task automatic run_window(input logic [31:0] base, input int cols, input int orow, input int ocol,
                              input int nc, input int nr, input bit stalls, input bit poke,
                              input int abort_at, output logic [31:0] fa, output logic [31:0] la,
                              output int nhs);
        int          r, c;
        bit          rdy, fin, is_last;
        logic [31:0] exp;
        r = 0; c = 0; nhs = 0; fin = 0; fa = '0; la = '0;
        for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
            start = poke && (nhs == 3);
            if (abort_at > 0 && nhs == abort_at) begin
                start       = 1'b0;
                ld.ld_ready = 1'b0;
                Rst         = 1'b1;
                tick();
                chk("abort_valid", ld.ld_valid, 0);
                chk("abort_busy", busy, 0);
                chk("abort_done", done, 0);
                Rst = 1'b0;
                return;
            end
            exp     = base + 32'(((orow + r) * cols + ocol + c) * 4);
            is_last = (r == nr - 1) && (c == nc - 1);
            chk("ld_valid", ld.ld_valid, 1);
            chk("ld_addr", ld.ld_addr, exp);
            chk("ld_last", ld.ld_last, is_last);
            chk("issue_busy", busy, 1);
            rdy = stalls ? ($urandom_range(0, 1) == 1) : 1'b1;
            ld.ld_ready = rdy;
            if (rdy) begin
                if (nhs == 0) fa = exp;
                nhs++;
                if (is_last) begin
                    la  = exp;
                    fin = 1'b1;
                end else if (c == nc - 1) begin
                    c = 0;
                    r++;
                end else begin
                    c++;
                end
            end
            tick();
        end
        start       = 1'b0;
        ld.ld_ready = 1'b0;
        if (!fin) begin
            chk("issue_timeout", 0, 1);
            return;
        end
        chk("fin_done", done, 1);
        chk("fin_busy", busy, 1);
        chk("fin_valid", ld.ld_valid, 0);
        start = poke;
        tick();
        start = 1'b0;
        chk("post_done", done, 0);
        chk("post_busy", busy, 0);
        tick();
        chk("idle_busy", busy, 0);
        chk("idle_valid", ld.ld_valid, 0);
    endtask

    initial begin
        Rst = 1'b1; start = 1'b0; wcol_code = '0; wrow_code = '0;
        frame_base = '0; frame_cols = '0; origin_row = '0; origin_col = '0;
        ld.ld_ready = 1'b0;

        // reset and idle
        tick();
        chk("rst_valid", ld.ld_valid, 0);
        chk("rst_addr", ld.ld_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        tick(); tick();
        Rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_valid", ld.ld_valid, 0);
            chk("idle_last", ld.ld_last, 0);
            chk("idle_busy", busy, 0);
            chk("idle_done", done, 0);
            chk("idle_err", err, 0);
        end

        // 4x4, no stalls
        start_window(2'd0, 2'd0, 32'h1000, 8'd64, 8'd2, 8'd3);
        run_window(32'h1000, 64, 2, 3, 4, 4, 0, 0, 0, first_a, last_a, hs);
        chk("w4_hs", hs, 16);
        chk("w4_first", first_a, 32'h120C);
        chk("w4_last", last_a, 32'h1518);

        // 16 cols x 8 rows with random stalls
        start_window(2'd2, 2'd1, 32'h2000_0000, 8'd40, 8'd5, 8'd7);
        run_window(32'h2000_0000, 40, 5, 7, 16, 8, 1, 0, 0, first_a, last_a, hs);
        chk("w16x8_hs", hs, 128);
        chk("w16x8_first", first_a, 32'h2000_033C);
        chk("w16x8_last", last_a, 32'h2000_07D8);

        // illegal column code, then a legal start
        wcol_code = 2'd3; wrow_code = 2'd0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("ill_err", err, 1);
        chk("ill_busy", busy, 0);
        chk("ill_valid", ld.ld_valid, 0);
        tick();
        chk("ill_err_clr", err, 0);
        chk("ill_busy2", busy, 0);
        chk("ill_valid2", ld.ld_valid, 0);
        start_window(2'd0, 2'd1, 32'h0000_0800, 8'd10, 8'd0, 8'd0);
        run_window(32'h0000_0800, 10, 0, 0, 4, 8, 0, 0, 0, first_a, last_a, hs);
        chk("after_ill_hs", hs, 32);

        // starts during ISSUE and in the done cycle are ignored
        start_window(2'd0, 2'd0, 32'h0000_4000, 8'd8, 8'd1, 8'd0);
        run_window(32'h0000_4000, 8, 1, 0, 4, 4, 1, 1, 0, first_a, last_a, hs);
        chk("poke_hs", hs, 16);

        // address wraps modulo 2^32 at the far frame corner
        start_window(2'd0, 2'd0, 32'hFFFF_FF00, 8'd255, 8'd255, 8'd255);
        run_window(32'hFFFF_FF00, 255, 255, 255, 4, 4, 0, 0, 0, first_a, last_a, hs);
        chk("wrap_first", first_a, 32'h0003_FB00);

        // reset after the 5th handshake of an 8x8 window, then restart
        start_window(2'd1, 2'd1, 32'h0000_0400, 8'd16, 8'd1, 8'd1);
        run_window(32'h0000_0400, 16, 1, 1, 8, 8, 0, 0, 5, first_a, last_a, hs);
        chk("abort_hs", hs, 5);
        tick();
        chk("abort_idle_done", done, 0);
        chk("abort_idle_busy", busy, 0);
        start_window(2'd1, 2'd1, 32'h0000_0400, 8'd16, 8'd1, 8'd1);
        run_window(32'h0000_0400, 16, 1, 1, 8, 8, 0, 0, 0, first_a, last_a, hs);
        chk("restart_first", first_a, 32'h0000_0444);
        chk("restart_hs", hs, 64);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
